// File: rtl/toggle_seq_stim_gen_pkg.sv
// Shared types for the toggle sequencer: state encodings, phase codes and
// small decode helpers used by the top-level FSM.
package toggle_seq_stim_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_A = 3'd1,
    ST_WAIT_B = 3'd2,
    ST_WAIT_C = 3'd3,
    ST_WAIT_D = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_B = 2'd1;
  localparam logic [1:0] PH_C = 2'd2;
  localparam logic [1:0] PH_D = 2'd3;

  function automatic logic is_wait(input state_t s);
    return (s == ST_WAIT_A) || (s == ST_WAIT_B) ||
           (s == ST_WAIT_C) || (s == ST_WAIT_D);
  endfunction

  function automatic state_t next_wait(input state_t s);
    case (s)
      ST_WAIT_A: return ST_WAIT_B;
      ST_WAIT_B: return ST_WAIT_C;
      ST_WAIT_C: return ST_WAIT_D;
      ST_WAIT_D: return ST_WAIT_A;
      default:   return s;
    endcase
  endfunction

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      ST_WAIT_B: return PH_B;
      ST_WAIT_C: return PH_C;
      ST_WAIT_D: return PH_D;
      default:   return PH_A;
    endcase
  endfunction

endpackage

// File: rtl/toggle_seq_stim_gen_if.sv
// Control and stimulus bundle between the sequencer (slave) and whatever
// drives start/pause and consumes a..d (master).
interface toggle_seq_stim_gen_if;
  logic       start;
  logic       pause;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       busy;
  logic       done;
  logic [1:0] phase;

  modport master (
    output start, pause,
    input  a, b, c, d, busy, done, phase
  );

  modport slave (
    input  start, pause,
    output a, b, c, d, busy, done, phase
  );
endinterface

// File: rtl/toggle_seq_stim_gen_dly_down_counter.sv
// Loadable down-counter that saturates at zero; load wins over enable.
module dly_down_counter #(
  parameter int unsigned CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/toggle_seq_stim_gen.sv
// Round-robin toggle sequencer driving a..d of the gate lab block; runs for
// RUN_LEN unpaused cycles after start, then freezes and flags done.
module toggle_seq_stim_gen
  import toggle_seq_stim_gen_pkg::*;
#(
  parameter int unsigned DLY_A   = 20,
  parameter int unsigned DLY_B   = 30,
  parameter int unsigned DLY_C   = 40,
  parameter int unsigned DLY_D   = 50,
  parameter int unsigned RUN_LEN = 1000,
  parameter int unsigned CW      = 10
) (
  input logic                  clk,
  input logic                  rst,
  toggle_seq_stim_gen_if.slave bus
);

  state_t        state_q, state_d;
  logic [CW-1:0] elapsed_q, elapsed_d;
  logic [3:0]    tgl_q, tgl_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [1:0]    phase_q, phase_d;

  logic          arm, active, run_end, expire;
  logic          dly_load, dly_zero;
  logic [CW-1:0] dly_load_val, next_dly, dly_cnt;

  assign arm     = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start;
  assign active  = is_wait(state_q) && !bus.pause;
  assign run_end = active && (elapsed_q == CW'(RUN_LEN - 1));
  assign expire  = active && dly_zero;

  always_comb begin
    case (phase_of(next_wait(state_q)))
      PH_A:    next_dly = CW'(DLY_A - 1);
      PH_B:    next_dly = CW'(DLY_B - 1);
      PH_C:    next_dly = CW'(DLY_C - 1);
      default: next_dly = CW'(DLY_D - 1);
    endcase
    dly_load     = arm || expire;
    dly_load_val = arm ? CW'(DLY_A - 1) : next_dly;
  end

  dly_down_counter #(.CW(CW)) u_dcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .load_val (dly_load_val),
    .en       (active),
    .cnt      (dly_cnt),
    .zero     (dly_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (dly_zero == (dly_cnt == '0));
    end
  end

  // Run end beats toggle expiry for the state, but the toggle itself still lands.
  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    if (arm) begin
      state_d   = ST_WAIT_A;
      elapsed_d = '0;
    end else if (run_end) begin
      state_d   = ST_DONE;
    end else if (active) begin
      elapsed_d = elapsed_q + CW'(1);
      if (dly_zero) begin
        state_d = next_wait(state_q);
      end
    end
  end

  always_comb begin
    tgl_d = tgl_q;
    if (arm) begin
      tgl_d = '0;
    end else if (expire) begin
      tgl_d[phase_of(state_q)] = ~tgl_q[phase_of(state_q)];
    end
    busy_d  = is_wait(state_d);
    done_d  = (state_d == ST_DONE);
    phase_d = phase_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      elapsed_q <= '0;
      tgl_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      phase_q   <= PH_A;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      tgl_q     <= tgl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      phase_q   <= phase_d;
    end
  end

  assign bus.a     = tgl_q[0];
  assign bus.b     = tgl_q[1];
  assign bus.c     = tgl_q[2];
  assign bus.d     = tgl_q[3];
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.phase = phase_q;

endmodule

// File: tb/tb_toggle_seq_stim_gen.sv
// Bench for toggle_seq_stim_gen: a default-parameter and a minimal-delay
// instance share the stimulus; a schedule-based model predicts every cycle.
module tb_toggle_seq_stim_gen;

  localparam int D_A = 20, D_B = 30, D_C = 40, D_D = 50, R_L = 1000;
  localparam int S_A = 1,  S_B = 1,  S_C = 1,  S_D = 1,  S_RL = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  toggle_seq_stim_gen_if bus_def ();
  toggle_seq_stim_gen_if bus_sml ();

  toggle_seq_stim_gen u_def (
    .clk (clk),
    .rst (rst),
    .bus (bus_def)
  );

  toggle_seq_stim_gen #(
    .DLY_A (S_A), .DLY_B (S_B), .DLY_C (S_C), .DLY_D (S_D),
    .RUN_LEN (S_RL), .CW (10)
  ) u_sml (
    .clk (clk),
    .rst (rst),
    .bus (bus_sml)
  );

  typedef struct {
    bit       run;
    bit       dn;
    int       n;
    bit [3:0] t;
  } mdl_t;

  mdl_t md, ms;
  logic [7:0] exp_def_q[$];
  logic [7:0] exp_sml_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n counts unpaused run edges; toggles fall at fixed offsets within a round.
  function automatic mdl_t mdl_step(mdl_t m, bit r, bit s, bit p,
                                    int da, int db, int dc, int dd, int rl);
    int per, q;
    per = da + db + dc + dd;
    if (r) begin
      m.run = 0; m.dn = 0; m.n = 0; m.t = '0;
    end else if (!m.run) begin
      if (s) begin
        m.run = 1; m.dn = 0; m.n = 0; m.t = '0;
      end
    end else if (!p) begin
      m.n++;
      q = m.n % per;
      if (q == da)           m.t[0] = ~m.t[0];
      if (q == da + db)      m.t[1] = ~m.t[1];
      if (q == da + db + dc) m.t[2] = ~m.t[2];
      if (q == 0)            m.t[3] = ~m.t[3];
      if (m.n == rl) begin
        m.run = 0; m.dn = 1;
      end
    end
    return m;
  endfunction

  function automatic logic [7:0] mdl_out(mdl_t m, int da, int db, int dc, int dd);
    int per, q;
    logic [1:0] ph;
    per = da + db + dc + dd;
    q   = m.n % per;
    ph  = 2'd0;
    if (m.run) begin
      if (q < da)                ph = 2'd0;
      else if (q < da + db)      ph = 2'd1;
      else if (q < da + db + dc) ph = 2'd2;
      else                       ph = 2'd3;
    end
    return {m.t[0], m.t[1], m.t[2], m.t[3], m.run, m.dn, ph};
  endfunction

  task automatic tick(input bit r, input bit s, input bit p);
    logic [7:0] e_def, e_sml;
    rst = r;
    bus_def.start = s; bus_def.pause = p;
    bus_sml.start = s; bus_sml.pause = p;
    md = mdl_step(md, r, s, p, D_A, D_B, D_C, D_D, R_L);
    ms = mdl_step(ms, r, s, p, S_A, S_B, S_C, S_D, S_RL);
    exp_def_q.push_back(mdl_out(md, D_A, D_B, D_C, D_D));
    exp_sml_q.push_back(mdl_out(ms, S_A, S_B, S_C, S_D));
    @(posedge clk);
    #1;
    cyc++;
    e_def = exp_def_q.pop_front();
    e_sml = exp_sml_q.pop_front();
    check($sformatf("def_out@%0d", cyc),
          {24'd0, bus_def.a, bus_def.b, bus_def.c, bus_def.d,
           bus_def.busy, bus_def.done, bus_def.phase}, {24'd0, e_def});
    check($sformatf("sml_out@%0d", cyc),
          {24'd0, bus_sml.a, bus_sml.b, bus_sml.c, bus_sml.d,
           bus_sml.busy, bus_sml.done, bus_sml.phase}, {24'd0, e_sml});
  endtask

  function automatic logic [3:0] abcd_def();
    return {bus_def.a, bus_def.b, bus_def.c, bus_def.d};
  endfunction

  initial begin
    md = '{run: 0, dn: 0, n: 0, t: '0};
    ms = '{run: 0, dn: 0, n: 0, t: '0};
    bus_def.start = 1'b0; bus_def.pause = 1'b0;
    bus_sml.start = 1'b0; bus_sml.pause = 1'b0;

    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    check("reset_outs", {24'd0, abcd_def(), bus_def.busy, bus_def.done, bus_def.phase}, 32'd0);

    // Full default run; the minimal instance runs alongside.
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 1020; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (i == 19)   check("a_before20", {31'd0, bus_def.a}, 32'd0);
      if (i == 20)   check("a_rise20",   {31'd0, bus_def.a}, 32'd1);
      if (i == 50)   check("b_rise50",   {31'd0, bus_def.b}, 32'd1);
      if (i == 90)   check("c_rise90",   {31'd0, bus_def.c}, 32'd1);
      if (i == 140)  check("d_rise140",  {31'd0, bus_def.d}, 32'd1);
      if (i == 160)  check("a_fall160",  {31'd0, bus_def.a}, 32'd0);
      if (i == 6) begin
        check("sml_abcd6", {28'd0, bus_sml.a, bus_sml.b, bus_sml.c, bus_sml.d}, 32'b0011);
        check("sml_done6", {31'd0, bus_sml.done}, 32'd1);
      end
      if (i == 999)  check("done_before", {31'd0, bus_def.done}, 32'd0);
      if (i == 1000) begin
        check("final_abcd", {28'd0, abcd_def()}, 32'b0111);
        check("done_1000",  {31'd0, bus_def.done}, 32'd1);
        check("busy_1000",  {31'd0, bus_def.busy}, 32'd0);
      end
      if (i == 1020) check("frozen_abcd", {28'd0, abcd_def()}, 32'b0111);
    end

    // Pause over edges 45..54 shifts the schedule by ten cycles.
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 1030; i++) begin
      tick(1'b0, 1'b0, (i >= 45 && i <= 54));
      if (i == 50)   check("pause_b50",   {31'd0, bus_def.b}, 32'd0);
      if (i == 52)   check("pause_busy",  {31'd0, bus_def.busy}, 32'd1);
      if (i == 60)   check("pause_b60",   {31'd0, bus_def.b}, 32'd1);
      if (i == 1009) check("pause_nd1009", {31'd0, bus_def.done}, 32'd0);
      if (i == 1010) check("pause_d1010", {31'd0, bus_def.done}, 32'd1);
    end

    // Start while busy is ignored.
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 1010; i++) begin
      tick(1'b0, (i == 70), 1'b0);
      if (i == 160)  check("rs_a_fall160", {31'd0, bus_def.a}, 32'd0);
      if (i == 1000) check("rs_final", {28'd0, abcd_def(), bus_def.done}, {28'd0, 4'b0111, 1'b1});
    end

    // Reset mid-run wins over a concurrent start.
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 94; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("rst_mid_outs", {24'd0, abcd_def(), bus_def.busy, bus_def.done, bus_def.phase}, 32'd0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);
    check("rst_idle", {31'd0, bus_def.busy}, 32'd0);

    // Start with pause in IDLE arms; pause then holds the run.
    tick(1'b0, 1'b1, 1'b1);
    check("arm_paused", {31'd0, bus_def.busy}, 32'd1);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, 1'b1);
    check("held_a", {31'd0, bus_def.a}, 32'd0);
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b0, 1'b0);
    check("resumed_a", {31'd0, bus_def.a}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
